mem_stage_unit: RTL
===================

Name: mem_stage_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register. It issues data-memory load and store transactions over a req/ack handshake and stalls the upstream pipeline while a transaction is pending. It produces a registered branch/JALR redirect pulse and owns the MEM/WB register with the writeback data mux. A timeout FSM aborts hung accesses and raises a sticky error.

Parameters:
TIMEOUT, 15, number of WAIT cycles without dmem_ack before the access is aborted; legal range 1..255; counter is 8 bits.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
RegWrite_m  in  1  EX/MEM register-write enable
MemRW_m  in  1  1 = store, 0 = no store
WBSel_m  in  2  00 = memory load, 01 = ALU, 10 = pc4, 11 = reserved
PCSel_m  in  1  taken branch; target is alu_m[7:0]
take_jalr_m  in  1  JALR taken
jalr_target_m  in  8  JALR target
alu_m  in  32  ALU result / memory address
rd2_m  in  32  store data
pc4_m  in  8  PC+4
rd_m  in  5  destination register
pc_m  in  8  instruction PC
dmem_req  out  1  access request
dmem_we  out  1  write enable, equals MemRW_m
dmem_addr  out  32  equals alu_m
dmem_wdata  out  32  equals rd2_m
dmem_ack  in  1  access complete; rdata valid in the same cycle
dmem_rdata  in  32  load data
mem_stall  out  1  freeze IF through EX/MEM (combinational)
redirect_valid  out  1  one-cycle redirect pulse (registered)
redirect_pc  out  8  redirect target (registered)
wb_valid  out  1  MEM/WB holds a retired instruction
wb_RegWrite  out  1  writeback enable
wb_rd  out  5  writeback register
wb_data  out  32  writeback data
wb_pc  out  8  PC of the retired instruction
timeout_err  out  1  sticky; set on abort, cleared only by rst
fwd_valid  out  1  MEM-stage forward valid (optional feature)
fwd_rd  out  5  forward register (optional feature)
fwd_data  out  32  forward data (optional feature)

Behaviour:
- Reset: state IDLE, counter 0. All registered outputs are 0: redirect_valid, redirect_pc, wb_*, timeout_err.
- Decode (combinational):
  - is_store = MemRW_m.
  - is_load = ~MemRW_m & RegWrite_m & (WBSel_m == 00).
  - mem_op = is_store | is_load.
  - An all-zero EX/MEM (reset or flushed) is a NOP.
- FSM states and transitions:
  - IDLE: dmem_req = mem_op. If mem_op & dmem_ack, complete in this cycle: mem_stall = 0, stay in IDLE. If mem_op & ~dmem_ack, mem_stall = 1, counter <= 1, go to WAIT. Without mem_op, mem_stall = 0.
  - WAIT: dmem_req = 1 and mem_stall = ~dmem_ack. On dmem_ack, complete and go to IDLE. If counter == TIMEOUT and ~dmem_ack, go to ABORT; otherwise counter increments.
  - ABORT: dmem_req = 0, mem_stall = 0. The instruction retires with wb_RegWrite = 0 and wb_valid = 1. timeout_err <= 1. Go to IDLE.
- Request stability: address, data and we stay stable while stalled, because EX/MEM is frozen by mem_stall.
- dmem_ack outside a request is ignored.
- Retire: the instruction retires on any edge where mem_stall = 0.
- MEM/WB update on retire:
  - wb_valid <= 1, wb_rd <= rd_m, wb_pc <= pc_m.
  - wb_RegWrite <= RegWrite_m & (rd_m != 0), forced to 0 in ABORT.
  - wb_data mux: WBSel 00 selects dmem_rdata, 01 selects alu_m, 10 selects {24'b0, pc4_m}, 11 selects 0.
- MEM/WB while stalled: insert a bubble (wb_valid = 0, wb_RegWrite = 0). A stalled instruction is never written back twice.
- Redirect:
  - On retire, redirect_valid <= PCSel_m | take_jalr_m; otherwise 0.
  - redirect_pc <= take_jalr_m ? jalr_target_m : alu_m[7:0]. JALR has priority when both are set.
  - Exactly one pulse is produced per instruction, regardless of stall length.
- Reset mid-WAIT: dmem_req drops immediately (asynchronous) and the FSM returns to IDLE. Memory-side cleanup is not this block's responsibility.

Optional Feature:
MEM_FWD_EN.
- Defined: fwd_valid = RegWrite_m & (rd_m != 0) & ~is_load, with fwd_rd = rd_m and fwd_data = the WBSel mux value (ALU or pc4). All are combinational from the EX/MEM inputs.
- Undefined: fwd_valid, fwd_rd and fwd_data are tied to 0. The ports remain present.

Test Plan:
- ALU op: RegWrite=1, WBSel=01, rd=5, alu=0x1234 -> next edge wb_valid=1, wb_RegWrite=1, wb_rd=5, wb_data=0x1234, mem_stall stays 0.
- Zero-wait load: WBSel=00, RegWrite=1, alu=0x40, dmem_ack=1 same cycle with rdata=0xDEADBEEF -> dmem_req=1, mem_stall=0, wb_data=0xDEADBEEF next edge.
- Store with 3-cycle ack delay: MemRW=1, alu=0x80, rd2=0xA5 -> dmem_req/we held 4 cycles, mem_stall=1 for 3 cycles, 3 bubbles, then wb_valid=1, wb_RegWrite=0.
- Timeout with TIMEOUT=4 and no ack -> mem_stall high 5 cycles, ABORT retire with wb_RegWrite=0, timeout_err=1 persisting until rst.
- JALR and branch together: take_jalr=1, jalr_target=0x3C, PCSel=1, alu=0x10, plus stalled load -> single redirect_valid pulse with redirect_pc=0x3C after retire; rd=0 write gives wb_RegWrite=0.
- Assert rst during WAIT -> dmem_req and all outputs 0 immediately; after release a new load completes normally.

Source files
------------

// File: rtl/mem_stage_unit.sv
// MEM stage: dmem req/ack access with timeout abort, redirect pulse, MEM/WB register.
// Optional MEM-stage forwarding path enabled by defining MEM_FWD_EN.
module mem_stage_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_m,
    input  logic        MemRW_m,
    input  logic [1:0]  WBSel_m,
    input  logic        PCSel_m,
    input  logic        take_jalr_m,
    input  logic [7:0]  jalr_target_m,
    input  logic [31:0] alu_m,
    input  logic [31:0] rd2_m,
    input  logic [7:0]  pc4_m,
    input  logic [4:0]  rd_m,
    input  logic [7:0]  pc_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        redirect_valid,
    output logic [7:0]  redirect_pc,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [7:0]  wb_pc,
    output logic        timeout_err,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;
    localparam logic [7:0] TO_CNT  = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req, stall, abort, retire;
    logic        is_store, is_load, mem_op;
    logic [31:0] wb_mux;

    logic        redir_v_q, redir_v_d;
    logic [7:0]  redir_pc_q, redir_pc_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_rw_q, wb_rw_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [7:0]  wb_pc_q, wb_pc_d;
    logic        terr_q, terr_d;

    assign is_store = MemRW_m;
    assign is_load  = ~MemRW_m & RegWrite_m & (WBSel_m == 2'b00);
    assign mem_op   = is_store | is_load;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req   = mem_op;
                stall = mem_op & ~dmem_ack;
                if (mem_op & ~dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            S_WAIT: begin
                req   = 1'b1;
                stall = ~dmem_ack;
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TO_CNT) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ABORT: begin
                abort   = 1'b1;
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Gate with rst so the request drops the instant reset asserts.
    assign dmem_req   = req & ~rst;
    assign mem_stall  = stall & ~rst;
    assign dmem_we    = MemRW_m;
    assign dmem_addr  = alu_m;
    assign dmem_wdata = rd2_m;
    assign retire     = ~mem_stall;

    always_comb begin
        case (WBSel_m)
            2'b00:   wb_mux = dmem_rdata;
            2'b01:   wb_mux = alu_m;
            2'b10:   wb_mux = {24'b0, pc4_m};
            default: wb_mux = 32'b0;
        endcase
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        redir_v_d  = 1'b0;
        redir_pc_d = redir_pc_q;
        terr_d     = terr_q | abort;
        if (retire) begin
            wb_valid_d = 1'b1;
            wb_rw_d    = RegWrite_m & (rd_m != 5'd0) & ~abort;
            wb_rd_d    = rd_m;
            wb_data_d  = wb_mux;
            wb_pc_d    = pc_m;
            redir_v_d  = PCSel_m | take_jalr_m;
            redir_pc_d = take_jalr_m ? jalr_target_m : alu_m[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= 8'd0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_pc_q    <= 8'd0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            terr_q     <= terr_d;
        end
    end

    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;
    assign wb_valid       = wb_valid_q;
    assign wb_RegWrite    = wb_rw_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign wb_pc          = wb_pc_q;
    assign timeout_err    = terr_q;

`ifdef MEM_FWD_EN
    assign fwd_valid = RegWrite_m & (rd_m != 5'd0) & ~is_load;
    assign fwd_rd    = rd_m;
    assign fwd_data  = wb_mux;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = 32'd0;
`endif

endmodule
